// File: rtl/dispense_controller.sv
// Execution side of the fluid dispenser: takes one priced order, collects coins,
// opens the selected valve for a timed interval per litre and owns the stock levels.
module dispense_controller #(
    parameter int unsigned WATER_INIT      = 100,
    parameter int unsigned JUICE_INIT      = 80,
    parameter int unsigned CHEM_INIT       = 60,
    parameter int unsigned TICKS_PER_LITRE = 4,
    parameter int unsigned PAY_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  fluid_type,
    input  logic [7:0]  volume_l,
    input  logic [15:0] amount_due,
    input  logic        coin_valid,
    input  logic [7:0]  coin_value,
    input  logic        cancel,
    output logic [2:0]  valve_open,
    output logic        busy,
    output logic        done,
    output logic [2:0]  status,
    output logic [15:0] change,
    output logic [15:0] refund,
    output logic [15:0] stock_water,
    output logic [15:0] stock_juice,
    output logic [15:0] stock_chem
);

    // state      | meaning
    // S_IDLE     | ready for an order; rejects bad orders in place
    // S_PAY      | accumulating coins, watching cancel and the coin-free timer
    // S_DISPENSE | valve open, stock drops by one at the end of each litre
    // S_FINISH   | valve closed, done pulse with status OK
    typedef enum logic [1:0] {S_IDLE, S_PAY, S_DISPENSE, S_FINISH} state_t;

    localparam logic [2:0] ST_NONE      = 3'd0;
    localparam logic [2:0] ST_OK        = 3'd1;
    localparam logic [2:0] ST_ERR_TYPE  = 3'd2;
    localparam logic [2:0] ST_ERR_ZERO  = 3'd3;
    localparam logic [2:0] ST_ERR_STOCK = 3'd4;
    localparam logic [2:0] ST_CANCELLED = 3'd5;
    localparam logic [2:0] ST_TIMEOUT   = 3'd6;

    localparam int TW  = (TICKS_PER_LITRE > 1) ? $clog2(TICKS_PER_LITRE) : 1;
    localparam int TOW = $clog2(PAY_TIMEOUT + 1);

    state_t          r_state;
    logic            r_req_ready;
    logic            r_busy;
    logic            r_done;
    logic [2:0]      r_status;
    logic [2:0]      r_valve;
    logic [15:0]     r_change;
    logic [15:0]     r_refund;
    logic [15:0]     r_stock_water;
    logic [15:0]     r_stock_juice;
    logic [15:0]     r_stock_chem;
    logic [1:0]      r_fluid;
    logic [7:0]      r_litres;
    logic [15:0]     r_due;
    logic [15:0]     r_paid;
    logic [TW-1:0]   r_tick;
    logic [TOW-1:0]  r_tmo;

    logic [16:0]     w_paid_sum;
    logic [15:0]     w_paid_new;
    logic [15:0]     w_req_stock;

    function automatic logic [2:0] f_valve(input logic [1:0] f);
        case (f)
            2'b00:   f_valve = 3'b001;
            2'b01:   f_valve = 3'b010;
            2'b10:   f_valve = 3'b100;
            default: f_valve = 3'b000;
        endcase
    endfunction

    // Paid total including this cycle's coin, clamped at 0xFFFF.
    assign w_paid_sum = {1'b0, r_paid} + (coin_valid ? {9'd0, coin_value} : 17'd0);
    assign w_paid_new = w_paid_sum[16] ? 16'hFFFF : w_paid_sum[15:0];

    always_comb begin
        w_req_stock = 16'd0;
        case (fluid_type)
            2'b00:   w_req_stock = r_stock_water;
            2'b01:   w_req_stock = r_stock_juice;
            2'b10:   w_req_stock = r_stock_chem;
            default: w_req_stock = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_status      <= ST_NONE;
            r_valve       <= 3'b000;
            r_change      <= 16'd0;
            r_refund      <= 16'd0;
            r_stock_water <= 16'(WATER_INIT);
            r_stock_juice <= 16'(JUICE_INIT);
            r_stock_chem  <= 16'(CHEM_INIT);
            r_fluid       <= 2'b00;
            r_litres      <= 8'd0;
            r_due         <= 16'd0;
            r_paid        <= 16'd0;
            r_tick        <= '0;
            r_tmo         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_change <= 16'd0;
                        r_refund <= 16'd0;
                        if (fluid_type == 2'b11) begin
                            r_status <= ST_ERR_TYPE;
                            r_done   <= 1'b1;
                        end else if (volume_l == 8'd0) begin
                            r_status <= ST_ERR_ZERO;
                            r_done   <= 1'b1;
                        end else if ({8'd0, volume_l} > w_req_stock) begin
                            r_status <= ST_ERR_STOCK;
                            r_done   <= 1'b1;
                        end else begin
                            r_status    <= ST_NONE;
                            r_fluid     <= fluid_type;
                            r_litres    <= volume_l;
                            r_due       <= amount_due;
                            r_paid      <= 16'd0;
                            r_tick      <= TW'(TICKS_PER_LITRE - 1);
                            r_tmo       <= TOW'(PAY_TIMEOUT);
                            r_req_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            if (amount_due == 16'd0) begin
                                r_state <= S_DISPENSE;
                                r_valve <= f_valve(fluid_type);
                            end else begin
                                r_state <= S_PAY;
                            end
                        end
                    end
                end
                S_PAY: begin
                    r_paid <= w_paid_new;
                    r_tmo  <= coin_valid ? TOW'(PAY_TIMEOUT) : r_tmo - TOW'(1);
                    // Cancel outranks a coin that would complete the payment.
                    if (cancel || (!coin_valid && r_tmo == TOW'(1))) begin
                        r_refund    <= w_paid_new;
                        r_status    <= cancel ? ST_CANCELLED : ST_TIMEOUT;
                        r_done      <= 1'b1;
                        r_paid      <= 16'd0;
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (w_paid_new >= r_due) begin
                        r_change <= w_paid_new - r_due;
                        r_state  <= S_DISPENSE;
                        r_valve  <= f_valve(r_fluid);
                    end
                end
                S_DISPENSE: begin
                    if (r_tick == '0) begin
                        r_tick   <= TW'(TICKS_PER_LITRE - 1);
                        r_litres <= r_litres - 8'd1;
                        case (r_fluid)
                            2'b00:   r_stock_water <= r_stock_water - 16'd1;
                            2'b01:   r_stock_juice <= r_stock_juice - 16'd1;
                            default: r_stock_chem  <= r_stock_chem - 16'd1;
                        endcase
                        if (r_litres == 8'd1) begin
                            r_state  <= S_FINISH;
                            r_valve  <= 3'b000;
                            r_done   <= 1'b1;
                            r_status <= ST_OK;
                        end
                    end else begin
                        r_tick <= r_tick - TW'(1);
                    end
                end
                S_FINISH: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign status      = r_status;
    assign valve_open  = r_valve;
    assign change      = r_change;
    assign refund      = r_refund;
    assign stock_water = r_stock_water;
    assign stock_juice = r_stock_juice;
    assign stock_chem  = r_stock_chem;

endmodule

// File: tb/tb_dispense_controller.sv
// Bench for dispense_controller: directed scenarios with literal expectations, then
// random traffic, all checked each cycle against an order-level behavioural model.
module tb_dispense_controller;

    localparam int TPL = 4;
    localparam int PT  = 255;
    localparam int INIT_W = 100, INIT_J = 80, INIT_C = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  fluid_type;
    logic [7:0]  volume_l;
    logic [15:0] amount_due;
    logic        coin_valid;
    logic [7:0]  coin_value;
    logic        cancel;
    logic [2:0]  valve_open;
    logic        busy;
    logic        done;
    logic [2:0]  status;
    logic [15:0] change;
    logic [15:0] refund;
    logic [15:0] stock_water;
    logic [15:0] stock_juice;
    logic [15:0] stock_chem;

    dispense_controller #(
        .WATER_INIT(INIT_W), .JUICE_INIT(INIT_J), .CHEM_INIT(INIT_C),
        .TICKS_PER_LITRE(TPL), .PAY_TIMEOUT(PT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .fluid_type(fluid_type), .volume_l(volume_l), .amount_due(amount_due),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
        .valve_open(valve_open), .busy(busy), .done(done), .status(status),
        .change(change), .refund(refund),
        .stock_water(stock_water), .stock_juice(stock_juice), .stock_chem(stock_chem)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Order-level model: mode 0 idle, 1 paying, 2 dispensing, 3 finishing.
    int   m_mode = 0;
    int   m_f, m_vol, m_due, m_paid, m_quiet, m_elapsed, m_base;
    int   m_stock [3] = '{INIT_W, INIT_J, INIT_C};
    bit   e_done = 1'b0;
    int   e_status = 0, e_change = 0, e_refund = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0;
            m_stock = '{INIT_W, INIT_J, INIT_C};
            e_done = 1'b0; e_status = 0; e_change = 0; e_refund = 0;
            m_paid = 0;
        end else begin
            e_done = 1'b0;
            case (m_mode)
                0: if (req_valid) begin
                    e_change = 0; e_refund = 0;
                    if (fluid_type == 2'd3) begin e_status = 2; e_done = 1'b1; end
                    else if (volume_l == 0) begin e_status = 3; e_done = 1'b1; end
                    else if (int'(volume_l) > m_stock[fluid_type]) begin e_status = 4; e_done = 1'b1; end
                    else begin
                        e_status = 0;
                        m_f = int'(fluid_type); m_vol = int'(volume_l); m_due = int'(amount_due);
                        m_paid = 0; m_quiet = 0; m_elapsed = 0; m_base = m_stock[m_f];
                        m_mode = (amount_due == 0) ? 2 : 1;
                    end
                end
                1: begin
                    if (coin_valid) begin
                        m_paid = m_paid + int'(coin_value);
                        if (m_paid > 65535) m_paid = 65535;
                        m_quiet = 0;
                    end else begin
                        m_quiet++;
                    end
                    if (cancel) begin
                        e_refund = m_paid; e_status = 5; e_done = 1'b1; m_mode = 0;
                    end else if (m_paid >= m_due) begin
                        e_change = m_paid - m_due; m_mode = 2;
                    end else if (m_quiet == PT) begin
                        e_refund = m_paid; e_status = 6; e_done = 1'b1; m_mode = 0;
                    end
                end
                2: begin
                    m_elapsed++;
                    m_stock[m_f] = m_base - m_elapsed / TPL;
                    if (m_elapsed == m_vol * TPL) begin
                        m_mode = 3; e_done = 1'b1; e_status = 1;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, (m_mode == 0) ? 1 : 0);
            chk("busy", busy, (m_mode != 0) ? 1 : 0);
            chk("valve_open", valve_open, (m_mode == 2) ? (32'd1 << m_f) : 32'd0);
            chk("done", done, e_done);
            chk("status", status, e_status);
            chk("change", change, e_change);
            chk("refund", refund, e_refund);
            chk("stock_water", stock_water, m_stock[0]);
            chk("stock_juice", stock_juice, m_stock[1]);
            chk("stock_chem", stock_chem, m_stock[2]);
        end
    end

    task automatic idle_inputs();
        req_valid = 1'b0; fluid_type = 2'd0; volume_l = 8'd0; amount_due = 16'd0;
        coin_valid = 1'b0; coin_value = 8'd0; cancel = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [7:0] v, input logic [15:0] due);
        fluid_type = f; volume_l = v; amount_due = due; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        fluid_type = 2'($urandom); volume_l = 8'($urandom); amount_due = 16'($urandom);
    endtask

    task automatic run_done(input int max, output int vcyc, output bit seen);
        vcyc = 0; seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (valve_open != 3'b000) vcyc++;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    int  vc, n, sel;
    bit  ok;

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_stock_water", stock_water, 100);
        chk("rst_valve", valve_open, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;

        // Free water order, 3 litres.
        send(2'd0, 8'd3, 16'd0);
        run_done(40, vc, ok);
        chk("t1_done_seen", ok, 1);
        chk("t1_valve_cycles", vc, 12);
        chk("t1_status", status, 1);
        chk("t1_change", change, 0);
        chk("t1_stock_water", stock_water, 97);
        @(negedge clk);
        chk("t1_ready_back", req_ready, 1);

        // Paid juice order with overpayment.
        send(2'd1, 8'd2, 16'd80);
        coin_valid = 1'b1; coin_value = 8'd50;
        @(negedge clk);
        coin_value = 8'd50;
        @(negedge clk);
        coin_valid = 1'b0;
        chk("t2_change", change, 20);
        chk("t2_valve", valve_open, 3'b010);
        run_done(40, vc, ok);
        chk("t2_done_seen", ok, 1);
        chk("t2_valve_cycles", vc, 8);
        chk("t2_status", status, 1);
        chk("t2_stock_juice", stock_juice, 78);
        @(negedge clk);

        // Rejections, back to back.
        send(2'd3, 8'd0, 16'd0);
        chk("t3_type_done", done, 1);
        chk("t3_type_status", status, 2);
        send(2'd0, 8'd0, 16'd0);
        chk("t3_zero_status", status, 3);
        send(2'd2, 8'd61, 16'd0);
        chk("t3_stock_status", status, 4);
        chk("t3_stock_chem", stock_chem, 60);
        @(negedge clk);

        // Cancel together with a coin that would complete payment.
        send(2'd2, 8'd5, 16'd40);
        coin_valid = 1'b1; coin_value = 8'd10;
        @(negedge clk);
        coin_value = 8'd30; cancel = 1'b1;
        @(negedge clk);
        coin_valid = 1'b0; cancel = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_status", status, 5);
        chk("t4_refund", refund, 40);
        chk("t4_stock_chem", stock_chem, 60);
        @(negedge clk);

        // Payment timeout after a single coin.
        send(2'd2, 8'd1, 16'd40);
        coin_valid = 1'b1; coin_value = 8'd5;
        @(negedge clk);
        coin_valid = 1'b0;
        n = 1;
        while (!done && n < 400) begin @(negedge clk); n++; end
        chk("t5_done_delay", n, 256);
        chk("t5_status", status, 6);
        chk("t5_refund", refund, 5);
        @(negedge clk);

        // Paid total saturates at 0xFFFF rather than wrapping.
        send(2'd0, 8'd1, 16'hFFFF);
        coin_valid = 1'b1; coin_value = 8'd100;
        @(negedge clk);
        coin_value = 8'd255;
        repeat (257) @(negedge clk);
        coin_valid = 1'b0;
        chk("t7_sat_valve", valve_open, 3'b001);
        chk("t7_sat_change", change, 0);
        run_done(20, vc, ok);
        chk("t7_done_seen", ok, 1);
        @(negedge clk);

        // Reset in the middle of a dispense.
        send(2'd0, 8'd5, 16'd0);
        repeat (9) @(negedge clk);
        chk("t6_mid_stock", stock_water, 94);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_valve", valve_open, 0);
        chk("t6_stock_water", stock_water, 100);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        reset = 1'b0;

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            req_valid  = ($urandom_range(3) == 0);
            fluid_type = 2'($urandom_range(3));
            sel = $urandom_range(9);
            if (sel < 6)
                volume_l = 8'($urandom_range(5));
            else if (sel < 8 && fluid_type != 2'd3)
                volume_l = 8'(m_stock[fluid_type] + $urandom_range(1));
            else
                volume_l = 8'($urandom_range(255));
            amount_due = ($urandom_range(2) == 0) ? 16'd0 : 16'($urandom_range(60));
            coin_valid = ($urandom_range(2) == 0);
            coin_value = 8'($urandom_range(30));
            cancel     = ($urandom_range(49) == 0);
            reset      = ($urandom_range(599) == 0);
            @(negedge clk);
        end

        reset = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
